round_timer_ctrl: RTL and testbench

Round sequencer for the game timer. Owns the per-second prescaler and the round-seconds countdown, and sequences the round through idle, running, paused and done states. It applies wrong-answer time penalties with saturation at zero. It sits between the player-input logic and the HEX display/score path, replacing the loose free-running pulse counters with one controlled timer.

---
 rtl/round_pkg.sv | 21 ++
 rtl/tick_prescaler.sv | 28 ++
 rtl/round_timer_ctrl.sv | 126 ++++++++++++
 tb/tb_round_timer_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared state encoding and default round constants for the game timer.
// ROUND_BONUS_EN (optional) enables correct-answer time bonus in round_timer_ctrl.
package round_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_RUN   = RUN,
    S_PAUSE = PAUSE,
    S_DONE  = DONE
  } state_t;

  localparam int ROUND_SECS   = 30;
  localparam int PENALTY_SECS = 2;
  localparam int BONUS_SECS   = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Game-second prescaler: down-counter from CLK_HZ-1, tick when it hits 0.
// Holds its value while enable is low; load forces a full reload.
module tick_prescaler #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || load) begin
      cnt <= TOP;
    end else if (enable) begin
      cnt <= (cnt == '0) ? TOP : cnt - CW'(1);
    end
  end

  assign tick = enable && (cnt == '0);

endmodule

// File: rtl/round_timer_ctrl.sv
// Round sequencer: IDLE/RUN/PAUSE/DONE, seconds countdown and penalties.
// Define ROUND_BONUS_EN to let correct answers add time (clamped to round length).
module round_timer_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int ROUND_SECS   = round_pkg::ROUND_SECS,
  parameter int PENALTY_SECS = round_pkg::PENALTY_SECS,
  parameter int BONUS_SECS   = round_pkg::BONUS_SECS,
  parameter int SEC_W        = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             wrong,
  input  logic             correct,
  output logic [SEC_W-1:0] secs_left,
  output logic             tick,
  output logic             running,
  output logic             time_up,
  output logic             game_over
);

  import round_pkg::*;

  localparam int AW = SEC_W + 1;
  localparam logic [SEC_W-1:0] FULL = SEC_W'(ROUND_SECS);

  state_t           state, state_nxt;
  logic [SEC_W-1:0] secs_q, secs_nxt, secs_run;
  logic             time_up_q;
  logic             tick_w;
  logic [AW-1:0]    dec;

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_pre (
    .clock (clock),
    .reset (reset),
    .load  ((state == S_IDLE) || (state == S_DONE)),
    .enable(state == S_RUN),
    .tick  (tick_w)
  );

  // Answer pulses lose to a same-cycle pause; the prescaler tick does not.
  always_comb begin
    dec = AW'(tick_w);
    if (wrong && !pause) dec = dec + AW'(PENALTY_SECS);
  end

`ifdef ROUND_BONUS_EN
  localparam int NW = SEC_W + 3;
  logic signed [NW-1:0] net;

  always_comb begin
    net = $signed({3'b000, secs_q}) - $signed({2'b00, dec});
    if (correct && !pause) net = net + $signed(NW'(BONUS_SECS));
    if (net <= 0) begin
      secs_run = '0;
    end else if (net >= $signed(NW'(ROUND_SECS))) begin
      secs_run = FULL;
    end else begin
      secs_run = net[SEC_W-1:0];
    end
  end
`else
  logic unused_bonus;
  assign unused_bonus = correct ^ (BONUS_SECS != 0);

  always_comb begin
    if ({1'b0, secs_q} <= dec) begin
      secs_run = '0;
    end else begin
      secs_run = secs_q - dec[SEC_W-1:0];
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    secs_nxt  = secs_q;
    unique case (state)
      S_IDLE: begin
        secs_nxt = FULL;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (secs_q == '0) begin
          state_nxt = S_DONE;
        end else begin
          secs_nxt = secs_run;
          if (pause) state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!pause) state_nxt = S_RUN;
      end
      S_DONE: begin
        secs_nxt = '0;
        if (start) begin
          state_nxt = S_RUN;
          secs_nxt  = FULL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      secs_q    <= FULL;
      time_up_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      secs_q    <= secs_nxt;
      time_up_q <= (state == S_RUN) && (secs_q == '0);
    end
  end

  assign secs_left = secs_q;
  assign tick      = tick_w;
  assign running   = (state == S_RUN);
  assign time_up   = time_up_q;
  assign game_over = (state == S_DONE);

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with CLK_HZ=4, ROUND_SECS=5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_round_timer_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       wrong = 1'b0;
  logic       correct = 1'b0;
  logic [5:0] secs_left;
  logic       tick, running, time_up, game_over;

  int total = 0;
  int bad = 0;

  round_timer_ctrl #(
    .CLK_HZ(4),
    .ROUND_SECS(5),
    .PENALTY_SECS(2),
    .BONUS_SECS(1),
    .SEC_W(6)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .wrong    (wrong),
    .correct  (correct),
    .secs_left(secs_left),
    .tick     (tick),
    .running  (running),
    .time_up  (time_up),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    wrong = 1'b0;
    correct = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // Leaves the bench in the first RUN cycle (prescaler = 3).
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!tick && n < 20) begin
      step();
      n++;
    end
  endtask

  int nt, first, tu, n;
  int tsecs[8];

  initial begin
    // reset state
    do_reset();
    chk("rst_secs", secs_left, 5);
    chk("rst_run", running, 0);
    chk("rst_tick", tick, 0);
    chk("rst_tup", time_up, 0);
    chk("rst_over", game_over, 0);

    // idle immunity
    wrong = 1'b1;
    step();
    wrong = 1'b0;
    chk("idle_wrong", secs_left, 5);
    chk("idle_run", running, 0);

    // full round
    do_start();
    chk("start_run", running, 1);
    nt = 0; first = -1; tu = 0;
    for (int i = 0; i < 40; i++) begin
      if (tick) begin
        if (nt == 0) first = i;
        if (nt < 8) tsecs[nt] = secs_left;
        nt++;
      end
      if (time_up) tu++;
      if (game_over) break;
      step();
    end
    chk("over", game_over, 1);
    chk("nticks", nt, 5);
    chk("first_tick", first, 3);
    chk("tup_cnt", tu, 1);
    for (int k = 0; k < 5; k++) chk("tick_secs", tsecs[k], 5 - k);
    chk("done_secs", secs_left, 0);
    step();
    chk("tup_pulse", time_up, 0);
    chk("over_hold", game_over, 1);

    // done immunity, then restart
    wrong = 1'b1;
    step(3);
    wrong = 1'b0;
    chk("done_wrong", secs_left, 0);
    chk("done_stay", game_over, 1);
    do_start();
    chk("restart_secs", secs_left, 5);
    chk("restart_run", running, 1);
    chk("restart_over", game_over, 0);

    // pause: second tick at R7, pause raised at R8
    do_reset();
    do_start();
    wait_tick(n);
    chk("p_t1", n, 3);
    step();
    wait_tick(n);
    chk("p_t2", n, 3);
    chk("p_t2_secs", secs_left, 4);
    step();
    chk("p_secs", secs_left, 3);
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p_tick", tick, 0);
      chk("p_hold", secs_left, 3);
    end
    chk("p_state", running, 0);
    pause = 1'b0;
    step();
    chk("p_resume", running, 1);
    wait_tick(n);
    chk("p_next", n, 2);
    chk("p_next_secs", secs_left, 3);

    // start mid-round is ignored
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("mid_start", secs_left, 2);

    // wrong together with tick at 4 -> 1
    do_reset();
    do_start();
    step(7);
    chk("sim_tick", tick, 1);
    chk("sim_secs", secs_left, 4);
    wrong = 1'b1;
    step();
    wrong = 1'b0;
    chk("sim_res", secs_left, 1);
    chk("sim_run", running, 1);

    // penalty saturation at 1
    do_reset();
    do_start();
    step(16);
    chk("sat_pre", secs_left, 1);
    wrong = 1'b1;
    step();
    wrong = 1'b0;
    chk("sat_zero", secs_left, 0);
    chk("sat_notyet", game_over, 0);
    step();
    chk("sat_over", game_over, 1);
    chk("sat_tup", time_up, 1);

    // reset mid-run at 2
    do_reset();
    do_start();
    step(12);
    chk("mr_pre", secs_left, 2);
    reset = 1'b1;
    step();
    chk("mr_secs", secs_left, 5);
    chk("mr_run", running, 0);
    chk("mr_tick", tick, 0);
    chk("mr_tup", time_up, 0);
    step(4);
    chk("mr_tick2", tick, 0);
    reset = 1'b0;

`ifdef ROUND_BONUS_EN
    do_reset();
    do_start();
    correct = 1'b1;
    step();
    correct = 1'b0;
    chk("bon_cap", secs_left, 5);
    step(8);
    chk("bon_pre", secs_left, 3);
    correct = 1'b1;
    step();
    correct = 1'b0;
    chk("bon_add", secs_left, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
